rx_block_assembler: RTL and testbench

RX_BLOCK_ASSEMBLER -- requirements
Module: rx_block_assembler

---
 rtl/rx_asm_pkg.sv | 21 ++
 rtl/rx_edge_det.sv | 24 ++
 rtl/rx_block_assembler.sv | 166 ++++++++++++++++
 tb/tb_rx_block_assembler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_asm_pkg.sv
// Shared definitions for the RX block assembler: default sizes, counter
// widths and the assembly state encoding.
package rx_asm_pkg;

  // Default bytes per assembled block and resulting block width
  localparam int NBYTES_DEF  = 16;
  localparam int BLK_W       = 8 * NBYTES_DEF;

  // Default inter-byte timeout in clk ticks (only used when the timeout is built in)
  localparam int TIMEOUT_DEF = 4096;

  // Width of the partial-block byte counter exposed on byte_cnt
  localparam int CNT_W       = 5;

  // Assembly state: EMPTY holds no bytes, COLLECT holds 1..NBYTES-1 bytes
  typedef enum logic {
    EMPTY   = 1'b0,
    COLLECT = 1'b1
  } asm_state_t;

endpackage

// File: rtl/rx_edge_det.sv
// Rising-edge detector built on a registered copy of the input level.
// The rise output is high on the first cycle the level is seen high after
// being low, so a level held high for many cycles produces a single event.
module rx_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_reg;

  // Remember the level from the previous cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= 1'b0;
    end else begin
      sig_reg <= sig;
    end
  end

  assign rise = sig & ~sig_reg;

endmodule

// File: rtl/rx_block_assembler.sv
// RX block assembler: packs UART receiver bytes into NBYTES-wide blocks,
// first byte in the most significant byte, and hands complete blocks to a
// consumer over a valid/ready pair. A block completing while the previous
// one is still unaccepted is dropped (ovf pulse); a receiver error discards
// the partial block (frame_err pulse).
//
// Build option: define RX_ASM_TIMEOUT_EN to add an inter-byte timeout that
// discards a partial block after TIMEOUT_TICKS idle ticks, exactly like a
// receiver error. Without it a partial block is held indefinitely.
//
// NBYTES must be in the range 2..31 so the partial count fits byte_cnt.
module rx_block_assembler
  import rx_asm_pkg::*;
#(
  parameter int NBYTES        = NBYTES_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_done,
  input  logic                  rx_err,
  input  logic [7:0]            rx_data,
  output logic [8*NBYTES-1:0]   blk_data,
  output logic                  blk_valid,
  input  logic                  blk_ready,
  output logic [CNT_W-1:0]      byte_cnt,
  output logic                  ovf,
  output logic                  frame_err
);

  localparam int W = 8 * NBYTES;

  asm_state_t        state_reg;
  logic [W-1:0]      asm_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [W-1:0]      blk_data_reg;
  logic              blk_valid_reg;
  logic              ovf_reg;
  logic              frame_err_reg;

  logic              done_rise;
  logic              err_rise;
  logic              timeout_hit;
  logic              err_evt;
  logic [W-1:0]      asm_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              blk_done;
  logic              out_free;

  // Edge detection on the receiver's byte-complete and error levels
  rx_edge_det u_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (rx_done),
    .rise  (done_rise)
  );

  rx_edge_det u_err_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (rx_err),
    .rise  (err_rise)
  );

`ifdef RX_ASM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TO_W-1:0] to_cnt_reg;

  // Idle-tick counter: runs only while collecting, restarts on every byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg != COLLECT || done_rise || err_rise) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == COLLECT) &&
                       (to_cnt_reg == TO_W'(TIMEOUT_TICKS - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A timeout behaves exactly like a receiver error
  assign err_evt   = err_rise | timeout_hit;

  // Candidate next assembly contents and count for an accepted byte
  assign asm_shift = {asm_reg[W-9:0], rx_data};
  assign cnt_inc   = cnt_reg + 1'b1;
  assign blk_done  = (cnt_inc == CNT_W'(NBYTES));

  // Output register can take a new block if empty or being accepted now
  assign out_free  = ~blk_valid_reg | blk_ready;

  // Assembly state machine together with the output block register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= EMPTY;
      asm_reg       <= '0;
      cnt_reg       <= '0;
      blk_data_reg  <= '0;
      blk_valid_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      ovf_reg       <= 1'b0;
      frame_err_reg <= 1'b0;

      // Consumer handshake empties the output; a completion below may refill it
      if (blk_valid_reg && blk_ready) begin
        blk_valid_reg <= 1'b0;
        blk_data_reg  <= '0;
      end

      case (state_reg)
        EMPTY: begin
          // An error edge alone does nothing here, but it still kills a
          // byte arriving on the same cycle
          if (done_rise && !err_rise) begin
            asm_reg   <= asm_shift;
            cnt_reg   <= cnt_inc;
            state_reg <= COLLECT;
          end
        end

        COLLECT: begin
          if (err_evt) begin
            asm_reg       <= '0;
            cnt_reg       <= '0;
            frame_err_reg <= 1'b1;
            state_reg     <= EMPTY;
          end else if (done_rise) begin
            if (blk_done) begin
              asm_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= EMPTY;
              if (out_free) begin
                blk_data_reg  <= asm_shift;
                blk_valid_reg <= 1'b1;
              end else begin
                ovf_reg <= 1'b1;
              end
            end else begin
              asm_reg <= asm_shift;
              cnt_reg <= cnt_inc;
            end
          end
        end

        default: begin
          state_reg <= EMPTY;
        end
      endcase
    end
  end

  assign blk_data  = blk_data_reg;
  assign blk_valid = blk_valid_reg;
  assign byte_cnt  = cnt_reg;
  assign ovf       = ovf_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_rx_block_assembler.sv
// Self-checking bench for rx_block_assembler: directed scenarios plus a
// randomized byte/error stream, checked by a scoreboard of expected blocks.
module tb_rx_block_assembler;

  localparam int NB = 16;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_done = 1'b0;
  logic          rx_err = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          blk_ready = 1'b0;
  logic [W-1:0]  blk_data;
  logic          blk_valid;
  logic [4:0]    byte_cnt;
  logic          ovf;
  logic          frame_err;

  always #5 clk = ~clk;

  rx_block_assembler #(.NBYTES(NB), .TIMEOUT_TICKS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_done   (rx_done),
    .rx_err    (rx_err),
    .rx_data   (rx_data),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .byte_cnt  (byte_cnt),
    .ovf       (ovf),
    .frame_err (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [7:0]   model_bytes[$];
  int           exp_ovf = 0;
  int           exp_frame = 0;
  bit           stalled = 1'b0;
  bit           pending = 1'b0;
  bit           rand_ready = 1'b0;

  // Monitor observations
  int           obs_ovf = 0;
  int           obs_frame = 0;
  logic [W-1:0] last_hs_data = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // A received byte joins the block; a full block is either queued for the
  // consumer or, if the consumer is stalled with a block already waiting, lost
  task automatic model_byte(input logic [7:0] d);
    logic [W-1:0] blk;
    model_bytes.push_back(d);
    if (model_bytes.size() == NB) begin
      blk = '0;
      foreach (model_bytes[i]) blk = {blk[W-9:0], model_bytes[i]};
      if (stalled && pending) begin
        exp_ovf++;
      end else begin
        exp_q.push_back(blk);
        if (stalled) pending = 1'b1;
      end
      model_bytes.delete();
    end
  endtask

  task automatic model_err();
    if (model_bytes.size() > 0) exp_frame++;
    model_bytes.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) blk_ready = ($urandom % 4) != 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int hold, input int gap, input bit with_err);
    tick();
    rx_data = d;
    rx_done = 1'b1;
    if (with_err) rx_err = 1'b1;
    tick();
    if (with_err) model_err();
    else model_byte(d);
    repeat (hold - 1) tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) tick();
    @(negedge clk);
    check("byte_cnt", W'(byte_cnt), W'(model_bytes.size()));
  endtask

  task automatic send_err(input int hold, input int gap);
    tick();
    rx_err = 1'b1;
    tick();
    model_err();
    repeat (hold - 1) tick();
    rx_err = 1'b0;
    repeat (gap) tick();
    @(negedge clk);
    check("byte_cnt_after_err", W'(byte_cnt), W'(model_bytes.size()));
  endtask

  // Monitor: pops and compares on every accepted block, counts pulses
  logic [W-1:0] prev_data = '0;
  bit           prev_valid = 1'b0;
  bit           prev_hs = 1'b0;

  always @(negedge clk) begin
    if (ovf) obs_ovf++;
    if (frame_err) obs_frame++;
    if (prev_valid && !prev_hs && blk_valid && rst_n)
      check("blk_data_stable", blk_data, prev_data);
    if (!blk_valid)
      check("blk_data_idle_zero", blk_data, '0);
    if (blk_valid && blk_ready) begin
      last_hs_data = blk_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block actual=%h required=none", blk_data);
      end else begin
        check("blk_data", blk_data, exp_q.pop_front());
      end
    end
    prev_data  = blk_data;
    prev_valid = blk_valid;
    prev_hs    = blk_valid & blk_ready;
  end

  initial begin
    int f0;
    int o0;
    int r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_blk_valid", W'(blk_valid), '0);
    check("rst_blk_data", blk_data, '0);
    check("rst_byte_cnt", W'(byte_cnt), '0);
    check("rst_ovf", W'(ovf), '0);
    check("rst_frame_err", W'(frame_err), '0);
    @(negedge clk);
    rst_n = 1'b1;
    blk_ready = 1'b1;

    // Sequential bytes 0x00..0x0F, long rx_done
    for (int i = 0; i < 16; i++) send_byte(8'(i), 16, 2, 1'b0);
    repeat (3) tick();
    check("seq_block", last_hs_data, 128'h000102030405060708090A0B0C0D0E0F);

    // Held-high rx_done counts once (byte_cnt check inside send_byte)
    send_byte(8'hA5, 16, 2, 1'b0);
    @(negedge clk);
    check("held_done_cnt", W'(byte_cnt), W'(1));
    for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1 + $urandom_range(0, 3), 1, 1'b0);

    // Error after 5 bytes, then a clean block
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 2, 1, 1'b0);
    f0 = obs_frame;
    send_err(3, 2);
    check("frame_err_once", W'(obs_frame - f0), W'(1));
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 2, 1, 1'b0);

    // Stalled consumer: second block dropped, first held
    repeat (4) tick();
    stalled = 1'b1;
    pending = 1'b0;
    blk_ready = 1'b0;
    o0 = obs_ovf;
    for (int i = 0; i < 32; i++) send_byte(8'($urandom), 2, 1, 1'b0);
    check("ovf_once", W'(obs_ovf - o0), W'(1));
    check("held_valid", W'(blk_valid), W'(1));
    if (exp_q.size() > 0) check("held_block", blk_data, exp_q[0]);
    stalled = 1'b0;
    pending = 1'b0;
    blk_ready = 1'b1;
    repeat (3) tick();

    // Idle gap after 3 bytes
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 2, 1, 1'b0);
    repeat (80) tick();
`ifdef RX_ASM_TIMEOUT_EN
    model_err();
`endif
    @(negedge clk);
    check("idle_gap_cnt", W'(byte_cnt), W'(model_bytes.size()));
    check("idle_gap_frame", W'(obs_frame), W'(exp_frame));

    // Randomized stream
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 85)      send_byte(8'($urandom), $urandom_range(1, 16), $urandom_range(1, 4), 1'b0);
      else if (r < 93) send_err($urandom_range(1, 4), $urandom_range(1, 3));
      else             send_byte(8'($urandom), $urandom_range(1, 8), $urandom_range(1, 3), 1'b1);
    end
    rand_ready = 1'b0;
    blk_ready = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < int'(NB) && model_bytes.size() != 0; i++) send_byte(8'($urandom), 2, 1, 1'b0);
    repeat (3) tick();

    // Reset with a pending block and a partial block
    stalled = 1'b1;
    blk_ready = 1'b0;
    for (int i = 0; i < 23; i++) send_byte(8'($urandom), 2, 1, 1'b0);
    f0 = obs_frame;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_blk_valid", W'(blk_valid), '0);
    check("arst_blk_data", blk_data, '0);
    check("arst_byte_cnt", W'(byte_cnt), '0);
    check("arst_ovf", W'(ovf), '0);
    check("arst_frame_err", W'(frame_err), '0);
    exp_q.delete();
    model_bytes.delete();
    stalled = 1'b0;
    pending = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_no_frame_pulse", W'(obs_frame - f0), '0);
    blk_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 2, 1, 1'b0);

    // Drain, bounded
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("exp_q_drained", W'(exp_q.size()), '0);
    check("ovf_total", W'(obs_ovf), W'(exp_ovf));
    check("frame_err_total", W'(obs_frame), W'(exp_frame));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
